// File: rtl/frame_update_scheduler_pkg.sv
// Shared display-path definitions for the frame update scheduler: widths,
// vertical timing constant, FSM encoding and the packed snapshot record.
package frame_update_scheduler_pkg;

    localparam int COORD_W  = 11;
    localparam int PIPE_N   = 3;
    localparam int PIPE_W   = PIPE_N * COORD_W;
    localparam int SCORE_W  = 8;
    localparam int GSTATE_W = 3;
    localparam int VCNT_W   = 11;
    localparam int V_ACTIVE = 480;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        COMMIT = 2'd2
    } sched_state_e;

    // Field order doubles as the concatenation order used to build it
    typedef struct packed {
        logic [COORD_W-1:0]  bird_h;
        logic [COORD_W-1:0]  bird_v;
        logic [COORD_W-1:0]  bird_blue_h;
        logic [COORD_W-1:0]  bird_blue_v;
        logic [PIPE_W-1:0]   pipe_pos;
        logic [SCORE_W-1:0]  score;
        logic [SCORE_W-1:0]  score1;
        logic [GSTATE_W-1:0] state;
    } snap_t;

endpackage

// File: rtl/frame_update_scheduler_if.sv
// Snapshot handshake between game logic (master) and the scheduler (slave).
interface frame_update_scheduler_if;
    import frame_update_scheduler_pkg::*;

    logic                snap_req;
    logic                snap_valid;
    logic [COORD_W-1:0]  bird_h_in;
    logic [COORD_W-1:0]  bird_v_in;
    logic [COORD_W-1:0]  bird_blue_h_in;
    logic [COORD_W-1:0]  bird_blue_v_in;
    logic [PIPE_W-1:0]   pipe_pos_in;
    logic [SCORE_W-1:0]  score_in;
    logic [SCORE_W-1:0]  score1_in;
    logic [GSTATE_W-1:0] state_in;

    modport master (
        input  snap_req,
        output snap_valid, bird_h_in, bird_v_in, bird_blue_h_in, bird_blue_v_in,
               pipe_pos_in, score_in, score1_in, state_in
    );

    modport slave (
        output snap_req,
        input  snap_valid, bird_h_in, bird_v_in, bird_blue_h_in, bird_blue_v_in,
               pipe_pos_in, score_in, score1_in, state_in
    );

endinterface

// File: rtl/frame_update_scheduler_vblank_edge_detect.sv
// Detects entry into vertical blanking from the VGA line counter.
module frame_update_scheduler_vblank_edge_detect
    import frame_update_scheduler_pkg::*;
#(
    parameter int V_ACTIVE = frame_update_scheduler_pkg::V_ACTIVE
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [VCNT_W-1:0] vcounter,
    output logic              in_vb,
    output logic              vb_rise
);

    logic vb_d;

    assign in_vb = (vcounter >= VCNT_W'(V_ACTIVE));

    // Reset to 1 so coming out of reset inside blanking is not seen as an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            vb_d <= 1'b1;
        end else begin
            vb_d <= in_vb;
        end
    end

    assign vb_rise = in_vb & ~vb_d;

endmodule

// File: rtl/frame_update_scheduler.sv
// Per-frame snapshot scheduler: requests game state at vblank entry, shadows it,
// and commits it to the display-facing registers so nothing changes mid-scan.
module frame_update_scheduler
    import frame_update_scheduler_pkg::*;
#(
    parameter int V_ACTIVE = frame_update_scheduler_pkg::V_ACTIVE,
    parameter int TIMEOUT  = 1024,
    parameter int CNT_W    = 16
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [VCNT_W-1:0]      vcounter,
    frame_update_scheduler_if.slave snap,
    output logic [COORD_W-1:0]     bird_h_q,
    output logic [COORD_W-1:0]     bird_v_q,
    output logic [COORD_W-1:0]     bird_blue_h_q,
    output logic [COORD_W-1:0]     bird_blue_v_q,
    output logic [PIPE_W-1:0]      pipe_pos_q,
    output logic [SCORE_W-1:0]     score_q,
    output logic [SCORE_W-1:0]     score1_q,
    output logic [GSTATE_W-1:0]    state_q,
    output logic                   frame_tick,
    output logic [CNT_W-1:0]       frame_cnt,
    output logic [7:0]             missed_cnt
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    sched_state_e     state, state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             in_vb;
    logic             vb_rise;
    logic             tmo_hit;
    logic             miss;
    snap_t            snap_in;
    snap_t            shadow_p0;
    snap_t            q_p1;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    frame_update_scheduler_vblank_edge_detect #(
        .V_ACTIVE (V_ACTIVE)
    ) u_vb (
        .clk      (clk),
        .rst      (rst),
        .vcounter (vcounter),
        .in_vb    (in_vb),
        .vb_rise  (vb_rise)
    );

    assign snap_in = {snap.bird_h_in, snap.bird_v_in, snap.bird_blue_h_in,
                      snap.bird_blue_v_in, snap.pipe_pos_in, snap.score_in,
                      snap.score1_in, snap.state_in};

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));

    // A valid snapshot wins over both timeout and active-video abort
    always_comb begin
        state_nxt = state;
        miss      = 1'b0;
        case (state)
            IDLE: begin
                if (vb_rise && enable) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (snap.snap_valid) begin
                    state_nxt = COMMIT;
                end else if (!in_vb || tmo_hit) begin
                    state_nxt = IDLE;
                    miss      = 1'b1;
                end
            end
            COMMIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tmo_cnt       <= '0;
            snap.snap_req <= 1'b0;
            frame_tick    <= 1'b0;
            frame_cnt     <= '0;
            missed_cnt    <= '0;
        end else begin
            state         <= state_nxt;
            tmo_cnt       <= (state == REQ) ? tmo_cnt + TMO_W'(1) : '0;
            snap.snap_req <= (state_nxt == REQ);
            frame_tick    <= (state == COMMIT);
            if (state == COMMIT) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
            if (miss) begin
                missed_cnt <= sat_inc8(missed_cnt);
            end
        end
    end

    // p0: shadow capture on the handshake; p1: commit to display-facing registers
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_p0 <= '0;
            q_p1      <= '0;
        end else begin
            if (state == REQ && snap.snap_valid) begin
                shadow_p0 <= snap_in;
            end
            if (state == COMMIT) begin
                q_p1 <= shadow_p0;
            end
        end
    end

    assign bird_h_q      = q_p1.bird_h;
    assign bird_v_q      = q_p1.bird_v;
    assign bird_blue_h_q = q_p1.bird_blue_h;
    assign bird_blue_v_q = q_p1.bird_blue_v;
    assign pipe_pos_q    = q_p1.pipe_pos;
    assign score_q       = q_p1.score;
    assign score1_q      = q_p1.score1;
    assign state_q       = q_p1.state;

endmodule

// File: doc/frame_update_scheduler.md
Name: frame_update_scheduler

Overview:
- Sequences per-frame transfer of game state into the display datapath so sprites, pipes and score never change mid-scan (no tearing).
- On each entry to vertical blanking it requests a snapshot from game logic over a req/valid handshake, latches it into shadow registers, then commits it to the registered outputs that feed the display module.
- If the snapshot does not arrive in time, the previous frame's values are held and a miss is counted.

Parameters:
- V_ACTIVE, 480, first vcounter value of vertical blanking (640x480 timing)
- TIMEOUT, 1024, max clk cycles spent in REQ before the frame is declared missed
- CNT_W, 16, width of frame_cnt

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  1 = schedule updates; 0 = ignore vblank events and hold outputs
- vcounter  in  11  VGA line counter, synchronous to clk
- snap_req  out  1  level; high while waiting for a snapshot
- snap_valid  in  1  game logic asserts when snapshot inputs are stable
- bird_h_in, bird_v_in, bird_blue_h_in, bird_blue_v_in  in  11 each  sprite positions
- pipe_pos_in  in  33  three packed 11-bit pipe positions, [10:0] = pipe 0
- score_in, score1_in  in  8 each  player scores
- state_in  in  3  game state code
- bird_h_q, bird_v_q, bird_blue_h_q, bird_blue_v_q, pipe_pos_q, score_q, score1_q, state_q  out  same widths  committed display values
- frame_tick  out  1  one-cycle pulse: committed values changed this cycle
- frame_cnt  out  CNT_W  committed frames, wraps
- missed_cnt  out  8  missed frames, saturates at 255

Behaviour:
- in_vb = (vcounter >= V_ACTIVE); registered copy vb_d; vb_rise = in_vb & ~vb_d.
- Reset: state IDLE; vb_d = 1, so a reset during blanking does not trigger; all _q outputs, shadows, frame_cnt, missed_cnt = 0; snap_req = 0; frame_tick = 0.
- FSM states: IDLE, REQ, COMMIT.
- IDLE:
  - vb_rise & enable -> REQ; clear timeout counter.
  - vb_rise with enable = 0 is dropped, not deferred.
- REQ:
  - snap_req = 1 (registered, first high the cycle after vb_rise).
  - Each cycle: if snap_valid, load all inputs into shadows at that edge -> COMMIT.
  - Else if ~in_vb (active video began) or timeout counter = TIMEOUT-1 -> IDLE, missed_cnt += 1 (saturating), outputs untouched.
  - snap_valid takes priority over timeout and abort in the same cycle.
  - Timeout counter increments while in REQ.
- COMMIT:
  - snap_req = 0.
  - Shadows copied to _q at end of cycle; frame_cnt += 1 (wraps).
  - frame_tick high the following cycle, coincident with new _q values.
  - -> IDLE unconditionally.
- Latency: snap_valid in cycle M -> new _q and frame_tick in cycle M+2.
- vb_rise while not IDLE is ignored. Only one update per blanking period.
- enable deasserted mid-REQ: the in-flight request still completes or times out.
- snap_valid outside REQ is ignored. Game logic must hold inputs stable in the cycle snap_valid is high.
- rst in any state returns to the reset values on the next edge; any in-flight snapshot is discarded.

Decomposition:
- Shared display package holds: FSM state encoding, V_ACTIVE, the 11-bit coordinate width, and the pipe packing widths (3 x 11).
- One natural sub-module, vblank_edge_detect: in_vb compare plus vb_d register, producing vb_rise and in_vb.
- Shadow and output registers stay inline.

Test Plan:
- Reset with vcounter=490 (inside blanking), hold 10 cycles -> no snap_req; then vcounter 0 -> 480 -> snap_req rises 1 cycle after the rise.
- vcounter reaches 480; snap_valid 5 cycles later with bird_h_in=100, score_in=7 -> bird_h_q=100 and score_q=7 exactly 2 cycles after snap_valid; frame_tick is a 1-cycle pulse; frame_cnt=1.
- Never assert snap_valid, TIMEOUT=8, vcounter held >= 480 -> snap_req drops after 8 cycles; missed_cnt=1; _q unchanged; no frame_tick.
- vcounter returns to 0 while in REQ, snap_valid never asserted -> abort to IDLE; missed_cnt increments; outputs unchanged.
- snap_valid in the same cycle as the timeout -> commit happens; missed_cnt unchanged.
- enable=0 across 3 frames -> no snap_req; frame_cnt constant. Also force 300 misses -> missed_cnt stays at 255.
